// File: rtl/dcache_mem_responder.sv
// -----------------------------------------------------------------------------
// dcache_mem_responder
//
// Behavioural backing-memory model for a data cache. It accepts one block
// request at a time, commits writes or snapshots reads at the acceptance edge,
// and returns a single-cycle resp_ready pulse a fixed LATENCY cycles later.
// A new request may be accepted in the same cycle as resp_ready, so back-to-back
// transactions keep identical latency.
//
// Ports
//   clock          in   rising-edge clock
//   reset_n        in   asynchronous active-low reset (storage is not cleared)
//   req_address    in   byte address of the requested block
//   req_data_in    in   block write data (DRAM_BLOCK_SIZE words)
//   req_rw         in   1 = block write, 0 = block read
//   req_valid      in   single-cycle request strobe
//   resp_data_out  out  registered block read data, held until the next read
//   resp_ready     out  single-cycle completion pulse (reads and writes)
//   busy           out  request outstanding and not yet completed
//   req_overrun    out  sticky: a request arrived while a transaction was pending
// -----------------------------------------------------------------------------
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 8
`endif

module dcache_mem_responder #(
    parameter int LATENCY      = 4,
    parameter int DEPTH_BLOCKS = 256
) (
    input  logic                                              clock,
    input  logic                                              reset_n,
    input  logic [`DRAM_ADDRESS_SIZE-1:0]                     req_address,
    input  logic [`DRAM_BLOCK_SIZE-1:0][`DRAM_WORD_SIZE-1:0]  req_data_in,
    input  logic                                              req_rw,
    input  logic                                              req_valid,
    output logic [`DRAM_BLOCK_SIZE-1:0][`DRAM_WORD_SIZE-1:0]  resp_data_out,
    output logic                                              resp_ready,
    output logic                                              busy,
    output logic                                              req_overrun
);

    typedef logic [`DRAM_BLOCK_SIZE-1:0][`DRAM_WORD_SIZE-1:0] block_t;

    // Block offset covers word-within-block plus byte-within-word (4 bytes).
    localparam int OFF_W = $clog2(`DRAM_BLOCK_SIZE) + 2;
    localparam int IDX_W = $clog2(DEPTH_BLOCKS);

    // WAIT spends LATENCY-2 decrementing cycles plus one exit cycle.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             rw_q, rw_d;
    logic             overrun_q, overrun_d;
    block_t           resp_q, resp_d;
    block_t           rd_q;
    block_t           mem_q [DEPTH_BLOCKS];

    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             addr_unused;

    // Offset and aliasing bits are deliberately dropped; fold them so the
    // whole address bus is visibly consumed.
    assign addr_unused = ^req_address;

    assign idx    = req_address[OFF_W+IDX_W-1:OFF_W];
    assign accept = reset_n && req_valid &&
                    ((state_q == ST_IDLE) || (state_q == ST_RESPOND));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        overrun_d = overrun_q;
        resp_d    = resp_q;
        case (state_q)
            ST_WAIT: begin
                // Requests during WAIT are dropped but remembered as an overrun.
                if (req_valid) begin
                    overrun_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESPOND;
                    if (!rw_q) begin
                        resp_d = rd_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                // IDLE and RESPOND both accept; RESPOND falls back to IDLE.
                state_d = ST_IDLE;
                if (accept) begin
                    rw_d = req_rw;
                    if (LATENCY == 1) begin
                        // RESPOND is entered at the acceptance edge itself, so
                        // the read data bypasses the capture register.
                        state_d = ST_RESPOND;
                        if (!req_rw) begin
                            resp_d = mem_q[idx];
                        end
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            rw_q      <= 1'b0;
            overrun_q <= 1'b0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            overrun_q <= overrun_d;
            resp_q    <= resp_d;
        end
    end

    // Storage and the read snapshot survive reset.
    always_ff @(posedge clock) begin
        if (accept && req_rw) begin
            mem_q[idx] <= req_data_in;
        end
        if (accept && !req_rw) begin
            rd_q <= mem_q[idx];
        end
    end

    assign resp_data_out = resp_q;
    assign resp_ready    = (state_q == ST_RESPOND);
    assign busy          = (state_q == ST_WAIT) ||
                           ((state_q == ST_RESPOND) && req_valid);
    assign req_overrun   = overrun_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
module tb_dcache_mem_responder;

    typedef logic [7:0][31:0] blk_t;

    logic clk;
    logic rst_n;

    // LATENCY=4 instance
    logic [31:0] a_addr;
    blk_t        a_din;
    logic        a_rw;
    logic        a_valid;
    blk_t        a_dout;
    logic        a_ready;
    logic        a_busy;
    logic        a_ovr;

    // LATENCY=1 instance
    logic [31:0] b_addr;
    blk_t        b_din;
    logic        b_rw;
    logic        b_valid;
    blk_t        b_dout;
    logic        b_ready;
    logic        b_busy;
    logic        b_ovr;

    int n_tests = 0;
    int n_fail  = 0;

    dcache_mem_responder #(.LATENCY(4), .DEPTH_BLOCKS(256)) u_dut (
        .clock        (clk),
        .reset_n      (rst_n),
        .req_address  (a_addr),
        .req_data_in  (a_din),
        .req_rw       (a_rw),
        .req_valid    (a_valid),
        .resp_data_out(a_dout),
        .resp_ready   (a_ready),
        .busy         (a_busy),
        .req_overrun  (a_ovr)
    );

    dcache_mem_responder #(.LATENCY(1), .DEPTH_BLOCKS(256)) u_dut_l1 (
        .clock        (clk),
        .reset_n      (rst_n),
        .req_address  (b_addr),
        .req_data_in  (b_din),
        .req_rw       (b_rw),
        .req_valid    (b_valid),
        .resp_data_out(b_dout),
        .resp_ready   (b_ready),
        .busy         (b_busy),
        .req_overrun  (b_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic blk_t mk(input logic [7:0] s);
        blk_t b;
        for (int i = 0; i < 8; i++) begin
            b[i] = {s, 8'(i), 16'hC0DE};
        end
        return b;
    endfunction

    // Drive one request in the current cycle; returns at the first negedge
    // after the acceptance edge.
    task automatic a_req(input logic [31:0] addr, input logic rw, input blk_t d);
        a_addr  = addr;
        a_rw    = rw;
        a_din   = d;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    // Counts negedges (starting at 1 for the current one) until resp_ready.
    task automatic a_wait(output int n);
        n = 1;
        while (!a_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        blk_t w1, w0, w3, w7, wbad, w2, wa;
        int   n;
        int   pulses;

        for (int i = 0; i < 8; i++) begin
            w1[i] = 32'h11111111 * 32'(i + 1);
        end
        w0   = mk(8'h00);
        w3   = mk(8'h33);
        w7   = mk(8'h77);
        wbad = mk(8'hEE);
        w2   = mk(8'h22);
        wa   = mk(8'hAA);

        rst_n   = 1'b0;
        a_addr  = '0; a_din = '0; a_rw = 1'b0; a_valid = 1'b0;
        b_addr  = '0; b_din = '0; b_rw = 1'b0; b_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready",   256'(a_ready), 256'(1'b0));
        check("rst_busy",    256'(a_busy),  256'(1'b0));
        check("rst_overrun", 256'(a_ovr),   256'(1'b0));
        check("rst_data",    256'(a_dout),  256'(0));
        check("rst_l1_ready", 256'(b_ready), 256'(1'b0));
        rst_n = 1'b1;

        // Write block at 0x140, first request right after reset release
        a_req(32'h0000_0140, 1'b1, w1);
        check("wr_busy_wait", 256'(a_busy), 256'(1'b1));
        a_wait(n);
        check("wr_latency", 256'(n), 256'(4));
        check("wr_data_held", 256'(a_dout), 256'(0));
        @(negedge clk);
        check("wr_ready_single", 256'(a_ready), 256'(1'b0));
        check("wr_busy_idle",    256'(a_busy),  256'(1'b0));

        // Read it back
        a_req(32'h0000_0140, 1'b0, '0);
        a_wait(n);
        check("rd_latency", 256'(n), 256'(4));
        check("rd_data",    256'(a_dout), 256'(w1));
        @(negedge clk);
        check("rd_data_hold_idle", 256'(a_dout), 256'(w1));

        // Preload block 7, then back-to-back write block 3 / read block 7
        a_req(32'h0000_00E0, 1'b1, w7);
        a_wait(n);
        @(negedge clk);
        a_req(32'h0000_0060, 1'b1, w3);
        check("b2b_busy_wait1", 256'(a_busy), 256'(1'b1));
        a_wait(n);
        check("b2b_lat1", 256'(n), 256'(4));
        a_addr  = 32'h0000_00E0;
        a_rw    = 1'b0;
        a_valid = 1'b1;
        #1;
        check("b2b_busy_respond", 256'(a_busy), 256'(1'b1));
        @(negedge clk);
        a_valid = 1'b0;
        check("b2b_busy_wait2", 256'(a_busy), 256'(1'b1));
        a_wait(n);
        check("b2b_lat2",    256'(n), 256'(4));
        check("b2b_data",    256'(a_dout), 256'(w7));
        check("b2b_overrun", 256'(a_ovr), 256'(1'b0));
        @(negedge clk);

        // Overrun: stray write two cycles into a pending read
        a_req(32'h0000_0140, 1'b0, '0);
        @(negedge clk);
        a_addr  = 32'h0000_0140;
        a_rw    = 1'b1;
        a_din   = wbad;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        check("ovr_flag", 256'(a_ovr), 256'(1'b1));
        a_wait(n);
        check("ovr_latency", 256'(n + 2), 256'(4));
        check("ovr_data",    256'(a_dout), 256'(w1));
        @(negedge clk);
        a_req(32'h0000_0140, 1'b0, '0);
        a_wait(n);
        check("ovr_no_write", 256'(a_dout), 256'(w1));
        check("ovr_sticky",   256'(a_ovr),  256'(1'b1));
        @(negedge clk);

        // Aliasing: index 0 reached through high bits and offset bits
        a_req(32'h0000_0000, 1'b1, w0);
        a_wait(n);
        @(negedge clk);
        a_req(32'h8000_201C, 1'b0, '0);
        a_wait(n);
        check("alias_latency", 256'(n), 256'(4));
        check("alias_data",    256'(a_dout), 256'(w0));
        @(negedge clk);

        // Reset during WAIT of a read of block 3
        a_req(32'h0000_0060, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data",  256'(a_dout),  256'(0));
        check("mid_rst_ready", 256'(a_ready), 256'(1'b0));
        check("mid_rst_ovr",   256'(a_ovr),   256'(1'b0));
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_ready) pulses++;
        end
        check("mid_rst_no_resp", 256'(pulses), 256'(0));
        check("mid_rst_data_after", 256'(a_dout), 256'(0));
        a_req(32'h0000_0060, 1'b0, '0);
        a_wait(n);
        check("mid_rst_reread_lat",  256'(n), 256'(4));
        check("mid_rst_reread_data", 256'(a_dout), 256'(w3));
        @(negedge clk);

        // LATENCY=1 instance: single write, single read
        b_addr = 32'h0000_0040; b_rw = 1'b1; b_din = w2; b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        check("l1_wr_ready", 256'(b_ready), 256'(1'b1));
        @(negedge clk);
        check("l1_wr_ready_low", 256'(b_ready), 256'(1'b0));
        b_addr = 32'h0000_0040; b_rw = 1'b0; b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        check("l1_rd_ready", 256'(b_ready), 256'(1'b1));
        check("l1_rd_data",  256'(b_dout),  256'(w2));
        @(negedge clk);
        check("l1_rd_ready_low", 256'(b_ready), 256'(1'b0));

        // LATENCY=1 instance: a request every cycle
        b_addr = 32'h0000_0080; b_rw = 1'b1; b_din = wa; b_valid = 1'b1;
        @(negedge clk);
        check("l1_seq_ready0", 256'(b_ready), 256'(1'b1));
        b_addr = 32'h0000_0080; b_rw = 1'b0;
        @(negedge clk);
        check("l1_seq_ready1", 256'(b_ready), 256'(1'b1));
        check("l1_seq_data1",  256'(b_dout),  256'(wa));
        b_addr = 32'h0000_0040; b_rw = 1'b0;
        @(negedge clk);
        b_valid = 1'b0;
        check("l1_seq_ready2", 256'(b_ready), 256'(1'b1));
        check("l1_seq_data2",  256'(b_dout),  256'(w2));
        @(negedge clk);
        check("l1_seq_idle",    256'(b_ready), 256'(1'b0));
        check("l1_seq_overrun", 256'(b_ovr),   256'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
